bank_word_serializer: RTL and testbench

- Upstream sequencer for the bank byte-select mux.
- Fetches a run of 32-bit words from a memory bank using a req/ack handshake and latches each word.
- Steps the 2-bit byte select through the word, presenting one byte per valid/ready handshake.
- Produces the `word`/`select` pair the mux consumes, plus a byte-valid flag for the downstream byte consumer.

---
 rtl/bank_word_serializer.sv | 185 ++++++++++++++++++
 tb/tb_bank_word_serializer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_word_serializer.sv
// Fetches a run of 32-bit words from a bank over req/ack and steps the byte select
// through each word under valid/ready. Optional macro: BANK_SERIALIZER_MSB_FIRST_EN.
`timescale 1ns/1ps

module bank_word_serializer #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       word_o,
   output logic [1:0]        sel_o,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 2;

`ifdef BANK_SERIALIZER_MSB_FIRST_EN
   localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(3);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(0);
`else
   localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(3);
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_mem_req;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_remaining;
   logic [DATA_W-1:0]   r_word;
   logic [SEL_W-1:0]    r_sel;
   logic                r_byte_valid;
   logic                r_busy;
   logic                r_done;

   logic                w_handshake;
   logic                w_last_byte;
   logic                w_load_cfg;
   logic                w_load_word;
   logic                w_step_sel;
   logic                w_word_end;
   logic                w_next_addr;
   logic                w_mem_req_nxt;
   logic                w_byte_valid_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;

   assign w_handshake = r_byte_valid & byte_ready;
   assign w_last_byte = (r_sel == SEL_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; abort overrides start, ack and handshake
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_state_nxt = (word_count == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (mem_ack) begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_handshake && w_last_byte) begin
               w_state_nxt = (r_remaining == ADDR_W'(1)) ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output/datapath strobes and next values of the registered outputs
   always_comb begin
      w_load_cfg       = 1'b0;
      w_load_word      = 1'b0;
      w_step_sel       = 1'b0;
      w_word_end       = 1'b0;
      w_next_addr      = 1'b0;
      w_mem_req_nxt    = (w_state_nxt == S_FETCH);
      w_byte_valid_nxt = (w_state_nxt == S_SHIFT);
      w_busy_nxt       = (w_state_nxt != S_IDLE);
      w_done_nxt       = (w_state_nxt == S_DONE);
      case (r_state)
         S_IDLE:  w_load_cfg  = start && !abort && (word_count != '0);
         S_FETCH: w_load_word = mem_ack && !abort;
         S_SHIFT: begin
            w_step_sel  = w_handshake && !abort && !w_last_byte;
            w_word_end  = w_handshake && !abort && w_last_byte;
            w_next_addr = w_word_end && (r_remaining != ADDR_W'(1));
         end
         default: ;
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_req    <= 1'b0;
         r_addr       <= '0;
         r_remaining  <= '0;
         r_word       <= '0;
         r_sel        <= '0;
         r_byte_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_mem_req    <= w_mem_req_nxt;
         r_byte_valid <= w_byte_valid_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         if (w_load_cfg) begin
            r_addr      <= base_addr;
            r_remaining <= word_count;
         end
         if (w_word_end) begin
            r_remaining <= r_remaining - ADDR_W'(1);
         end
         if (w_next_addr) begin
            r_addr <= r_addr + ADDR_W'(1);
         end
         if (w_load_word) begin
            r_word <= mem_rdata;
            r_sel  <= SEL_FIRST;
         end
`ifdef BANK_SERIALIZER_MSB_FIRST_EN
         if (w_step_sel) begin
            r_sel <= r_sel - SEL_W'(1);
         end
`else
         if (w_step_sel) begin
            r_sel <= r_sel + SEL_W'(1);
         end
`endif
      end
   end

   assign mem_req    = r_mem_req;
   assign mem_addr   = r_addr;
   assign word_o     = r_word;
   assign sel_o      = r_sel;
   assign byte_valid = r_byte_valid;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_bank_word_serializer.sv
// Scoreboard bench for bank_word_serializer: bank model, ready driver, byte monitor.
`timescale 1ns/1ps

module tb_bank_word_serializer;

   localparam int unsigned ADDR_W    = 8;
   localparam int          BANK_LAT  = 2;
   localparam int          TIMEOUT   = 200;

`ifdef BANK_SERIALIZER_MSB_FIRST_EN
   localparam logic [1:0] EXP_SEL_LAST = 2'd0;
`else
   localparam logic [1:0] EXP_SEL_LAST = 2'd3;
`endif

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] word_count;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   logic [31:0]       word_o;
   logic [1:0]        sel_o;
   logic              byte_valid;
   logic              byte_ready;
   logic              busy;
   logic              done;
   logic [7:0]        mux_byte;

   int n_tests = 0;
   int n_fail  = 0;

   logic [9:0]        exp_bytes[$];
   logic [ADDR_W-1:0] exp_addr[$];

   int cyc = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, req_rises = 0, hs_cnt = 0;
   int spur_req = 0, spur_done = 0, ready_mode = 0;

   bank_word_serializer #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .base_addr  (base_addr),
      .word_count (word_count),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .word_o     (word_o),
      .sel_o      (sel_o),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .busy       (busy),
      .done       (done)
   );

   // Downstream byte mux fed by the word/select pair
   assign mux_byte = word_o[{sel_o, 3'b000} +: 8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] bank_data(input logic [ADDR_W-1:0] a);
      case (a)
         8'h10:   bank_data = 32'hA1B2C3D4;
         8'hFE:   bank_data = 32'h11223344;
         8'hFF:   bank_data = 32'h55667788;
         8'h00:   bank_data = 32'h99AABBCC;
         default: bank_data = {4{a}};
      endcase
   endfunction

   // Expected {sel, byte} pairs for one word in output order
   task automatic push_word(input logic [31:0] w);
`ifdef BANK_SERIALIZER_MSB_FIRST_EN
      exp_bytes.push_back({2'd3, w[31:24]});
      exp_bytes.push_back({2'd2, w[23:16]});
      exp_bytes.push_back({2'd1, w[15:8]});
      exp_bytes.push_back({2'd0, w[7:0]});
`else
      exp_bytes.push_back({2'd0, w[7:0]});
      exp_bytes.push_back({2'd1, w[15:8]});
      exp_bytes.push_back({2'd2, w[23:16]});
      exp_bytes.push_back({2'd3, w[31:24]});
`endif
   endtask

   task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; word_count = c;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (n < TIMEOUT) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      check({name, "_idle"}, 64'(busy), 64'(0));
   endtask

   // Bank model: acks BANK_LAT cycles after request, checks the requested address
   initial begin
      int lat = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
            lat = 0;
         end else if (spur_req != spur_done) begin
            spur_done++;
            mem_ack = 1'b1;
            mem_rdata = 32'hDEADBEEF;
         end else if (mem_req) begin
            lat++;
            if (lat == BANK_LAT) begin
               check("addr_queue_nonempty", 64'(exp_addr.size() != 0), 64'(1));
               if (exp_addr.size() != 0) check("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
               mem_ack = 1'b1;
               mem_rdata = bank_data(mem_addr);
            end
         end else begin
            lat = 0;
         end
      end
   end

   // Ready driver: 0 always ready, 1 pattern 0,0,1, 2 ready except at select 2
   initial begin
      int rc = 0;
      byte_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         rc++;
         case (ready_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = (rc % 3 == 0);
            default: byte_ready = (sel_o != 2'd2);
         endcase
      end
   end

   // Monitor: pops the scoreboard on every byte handshake, checks hold under stall
   initial begin
      logic       prev_stall = 1'b0;
      logic       prev_req = 1'b0;
      logic [1:0] prev_sel = '0;
      logic [31:0] prev_word = '0;
      logic [9:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (mem_req && !prev_req) req_rises++;
         prev_req = mem_req;
         if (prev_stall)
            check("hold_while_stalled", 64'({byte_valid, sel_o, word_o}), 64'({1'b1, prev_sel, prev_word}));
         if (byte_valid && byte_ready && !abort) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            check("byte_queue_nonempty", 64'(exp_bytes.size() != 0), 64'(1));
            if (exp_bytes.size() != 0) begin
               e = exp_bytes.pop_front();
               check("sel_o", 64'(sel_o), 64'(e[9:8]));
               check("mux_byte", 64'(mux_byte), 64'(e[7:0]));
            end
         end
         prev_stall = byte_valid && !byte_ready && !abort && rst_n;
         prev_sel = sel_o;
         prev_word = word_o;
      end
   end

   initial begin
      int d0, r0, h0, n;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", 64'(mem_req), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_word_o", 64'(word_o), 64'(0));
      check("rst_sel_o", 64'(sel_o), 64'(0));
      check("rst_byte_valid", 64'(byte_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single word, ready high
      exp_addr.push_back(8'h10);
      push_word(32'hA1B2C3D4);
      d0 = done_cnt; r0 = req_rises;
      start_xfer(8'h10, 8'd1);
      wait_idle("single");
      check("single_done_pulses", 64'(done_cnt - d0), 64'(1));
      check("single_bytes_left", 64'(exp_bytes.size()), 64'(0));
      check("single_word_o", 64'(word_o), 64'(32'hA1B2C3D4));
      check("single_sel_final", 64'(sel_o), 64'(EXP_SEL_LAST));
      // Ack while idle must not disturb the latched word
      spur_req++;
      repeat (3) @(negedge clk);
      check("spur_ack_word_o", 64'(word_o), 64'(32'hA1B2C3D4));
      check("spur_ack_busy", 64'(busy), 64'(0));
      check("single_req_rises", 64'(req_rises - r0), 64'(1));

      // Three words across the address wrap, plus an ignored start mid-transfer
      exp_addr.push_back(8'hFE); exp_addr.push_back(8'hFF); exp_addr.push_back(8'h00);
      push_word(32'h11223344); push_word(32'h55667788); push_word(32'h99AABBCC);
      d0 = done_cnt; h0 = hs_cnt;
      start_xfer(8'hFE, 8'd3);
      repeat (5) @(posedge clk);
      #1 start = 1'b1; base_addr = 8'h40; word_count = 8'd1;
      @(posedge clk); #1 start = 1'b0;
      wait_idle("wrap");
      check("wrap_done_pulses", 64'(done_cnt - d0), 64'(1));
      check("wrap_handshakes", 64'(hs_cnt - h0), 64'(12));
      check("wrap_done_timing", 64'(done_cyc), 64'(last_hs_cyc + 1));
      check("wrap_final_addr", 64'(mem_addr), 64'(8'h00));
      check("wrap_bytes_left", 64'(exp_bytes.size()), 64'(0));
      check("wrap_addrs_left", 64'(exp_addr.size()), 64'(0));

      // Backpressure
      ready_mode = 1;
      exp_addr.push_back(8'h10);
      push_word(32'hA1B2C3D4);
      d0 = done_cnt; h0 = hs_cnt;
      start_xfer(8'h10, 8'd1);
      wait_idle("bp");
      ready_mode = 0;
      check("bp_handshakes", 64'(hs_cnt - h0), 64'(4));
      check("bp_bytes_left", 64'(exp_bytes.size()), 64'(0));
      check("bp_done_pulses", 64'(done_cnt - d0), 64'(1));

      // Zero count goes straight to DONE
      r0 = req_rises;
      start_xfer(8'h20, 8'd0);
      @(negedge clk);
      check("zero_done", 64'(done), 64'(1));
      check("zero_busy", 64'(busy), 64'(1));
      check("zero_mem_req", 64'(mem_req), 64'(0));
      @(negedge clk);
      check("zero_busy_after", 64'(busy), 64'(0));
      check("zero_done_after", 64'(done), 64'(0));
      check("zero_req_rises", 64'(req_rises - r0), 64'(0));

      // Start and abort together in IDLE: abort wins
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; base_addr = 8'h10; word_count = 8'd1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("sa_busy", 64'(busy), 64'(0));
      check("sa_mem_req", 64'(mem_req), 64'(0));

      // Abort in SHIFT at select 2
      ready_mode = 2;
      exp_addr.push_back(8'h10);
`ifdef BANK_SERIALIZER_MSB_FIRST_EN
      exp_bytes.push_back({2'd3, 8'hA1});
`else
      exp_bytes.push_back({2'd0, 8'hD4});
      exp_bytes.push_back({2'd1, 8'hC3});
`endif
      d0 = done_cnt;
      start_xfer(8'h10, 8'd1);
      n = 0;
      while (n < TIMEOUT && !(byte_valid && sel_o == 2'd2)) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_reach_sel2", 64'({byte_valid, sel_o}), 64'({1'b1, 2'd2}));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_byte_valid", 64'(byte_valid), 64'(0));
      check("abort_mem_req", 64'(mem_req), 64'(0));
      check("abort_sel_kept", 64'(sel_o), 64'(2));
      check("abort_word_kept", 64'(word_o), 64'(32'hA1B2C3D4));
      repeat (3) @(negedge clk);
      check("abort_no_done", 64'(done_cnt - d0), 64'(0));
      check("abort_bytes_left", 64'(exp_bytes.size()), 64'(0));
      ready_mode = 0;

      // Transfer after abort runs normally
      exp_addr.push_back(8'hFF);
      push_word(32'h55667788);
      d0 = done_cnt;
      start_xfer(8'hFF, 8'd1);
      wait_idle("post_abort");
      check("post_abort_done", 64'(done_cnt - d0), 64'(1));
      check("post_abort_bytes_left", 64'(exp_bytes.size()), 64'(0));

      // Reset during FETCH drops everything immediately
      start_xfer(8'h10, 8'd1);
      check("fetch_mem_req", 64'(mem_req), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_mem_req", 64'(mem_req), 64'(0));
      check("rst_mid_outputs", 64'({mem_addr, word_o, sel_o, byte_valid, busy, done}), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_mid_stays_idle", 64'({busy, mem_req}), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
